// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared types and sizing helpers for the TDM receive demultiplexer.
//   tdm_state_e : framing state (HUNT = searching for sync, LOCKED = tracking)
//   frame_len   : bits per frame = channels * width
//   cnt_width   : counter width able to index 0..n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    function automatic int frame_len(input int channels, input int width);
        return channels * width;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_shift_in.sv
// -----------------------------------------------------------------------------
// tdm_shift_in
// Serial-in frame shift register. Bits arrive first-bit-first; the first bit
// of a frame ends up in the MSB of o_img once the whole frame has arrived.
// Only F-1 bits are stored: o_img appends the live i_din as the LSB so the
// parent can latch a complete frame on the same edge that samples the last bit.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous reset, active-high
//   i_en    : shift enable (from parent FSM)
//   i_start : start of frame; clears the history and loads i_din as bit 0
//   i_din   : serial data bit
//   o_img   : F-bit frame image {stored bits, i_din}
// -----------------------------------------------------------------------------
module tdm_shift_in #(
    parameter int F = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_start,
    input  logic         i_din,
    output logic [F-1:0] o_img
);

    logic [F-2:0] r_sr;
    logic [F-1:0] w_shift;

    assign w_shift = {r_sr, i_din};
    assign o_img   = w_shift;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr <= '0;
        end else if (i_en) begin
            if (i_start) begin
                r_sr <= (F-1)'(i_din);
            end else begin
                r_sr <= w_shift[F-2:0];
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Receive-side TDM demultiplexer: locks onto frame sync, deserialises each
// frame (channel 0 first, MSB first) and presents all channels in parallel
// with a one-cycle frame_valid pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   HUNT   | no lock; waiting for en & fs to start a frame
//   LOCKED | tracking frames; flywheels over up to MAX_MISS-1 missing syncs
//
// Ports:
//   i_clk         : clock, rising edge
//   i_rst         : synchronous reset, active-high
//   i_en          : bit strobe; i_din / i_fs sampled only when high
//   i_din         : serial data
//   i_fs          : frame sync, high with the first bit of a frame
//   o_ch_data     : parallel frame, channel c at [c*WIDTH +: WIDTH]
//   o_frame_valid : one-cycle pulse when o_ch_data updates
//   o_locked      : high while LOCKED
//   o_sync_err    : one-cycle pulse after a misplaced fs
// -----------------------------------------------------------------------------
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_MISS = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_din,
    input  logic                      i_fs,
    output logic [CHANNELS*WIDTH-1:0] o_ch_data,
    output logic                      o_frame_valid,
    output logic                      o_locked,
    output logic                      o_sync_err
);

    localparam int F  = frame_len(CHANNELS, WIDTH);
    localparam int CW = cnt_width(F);
    localparam int MW = cnt_width(MAX_MISS + 1);

    tdm_state_e     r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt,   w_cnt_nxt;
    logic [MW-1:0]  r_miss,  w_miss_nxt;
    logic           w_sr_en, w_sr_start, w_done, w_serr;
    logic [F-1:0]   w_img;
    logic [F-1:0]   w_frame;

    tdm_shift_in #(.F(F)) u_shift (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_sr_en),
        .i_start (w_sr_start),
        .i_din   (i_din),
        .o_img   (w_img)
    );

    // The shift image holds the first wire bit in its MSB, so channel 0 sits
    // in the top WIDTH bits; swap channel order for the output layout.
    always_comb begin
        w_frame = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_frame[c*WIDTH +: WIDTH] = w_img[(CHANNELS-1-c)*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_miss_nxt  = r_miss;
        w_sr_en     = 1'b0;
        w_sr_start  = 1'b0;
        w_done      = 1'b0;
        w_serr      = 1'b0;
        if (i_en) begin
            case (r_state)
                HUNT: begin
                    if (i_fs) begin
                        w_sr_en     = 1'b1;
                        w_sr_start  = 1'b1;
                        w_cnt_nxt   = CW'(1);
                        w_miss_nxt  = '0;
                        w_state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (r_cnt == '0) begin
                        if (i_fs) begin
                            w_sr_en    = 1'b1;
                            w_sr_start = 1'b1;
                            w_cnt_nxt  = CW'(1);
                            w_miss_nxt = '0;
                        end else if (r_miss == MW'(MAX_MISS - 1)) begin
                            // This miss is the MAX_MISS-th: drop lock, bit discarded.
                            w_state_nxt = HUNT;
                            w_cnt_nxt   = '0;
                            w_miss_nxt  = '0;
                        end else begin
                            w_sr_en    = 1'b1;
                            w_sr_start = 1'b1;
                            w_cnt_nxt  = CW'(1);
                            w_miss_nxt = r_miss + MW'(1);
                        end
                    end else if (i_fs) begin
                        // Misplaced sync: abandon the partial frame, restart here.
                        w_serr     = 1'b1;
                        w_sr_en    = 1'b1;
                        w_sr_start = 1'b1;
                        w_cnt_nxt  = CW'(1);
                        w_miss_nxt = '0;
                    end else begin
                        w_sr_en = 1'b1;
                        if (r_cnt == CW'(F - 1)) begin
                            w_done    = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= HUNT;
            r_cnt         <= '0;
            r_miss        <= '0;
            o_ch_data     <= '0;
            o_frame_valid <= 1'b0;
            o_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_miss        <= w_miss_nxt;
            o_frame_valid <= w_done;
            o_sync_err    <= w_serr;
            if (w_done) begin
                o_ch_data <= w_frame;
            end
        end
    end

    assign o_locked = (r_state == LOCKED);

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer at the receive end of the team's serial TDM link. The transmit side drives a mux select counter to interleave channels onto one wire. This block does the reverse:
- locks onto the frame sync;
- deserialises each slot back into its channel register;
- presents all channels in parallel with a per-frame valid pulse.

It sits between the serial line interface and the parallel channel consumers.

## Interface
- CHANNELS, 4, number of channels per frame (≥2)
- WIDTH, 8, bits per channel per frame
- MAX_MISS, 3, consecutive missing syncs tolerated before losing lock (≥1)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  bit strobe; din/fs sampled only when high
- din  in  1  serial data bit
- fs  in  1  frame sync, high with the first bit of a frame
- ch_data  out  CHANNELS*WIDTH  parallel frame; channel c at [c*WIDTH +: WIDTH]
- frame_valid  out  1  one-cycle pulse when ch_data updates
- locked  out  1  high while state is LOCKED
- sync_err  out  1  one-cycle pulse on early (misplaced) fs

## Operation
- Frame length F = CHANNELS*WIDTH bits, sent channel 0 first, each channel MSB first.
- Bit counter cnt, 0..F-1, wraps F-1 → 0. Miss counter miss, 0..MAX_MISS.
- **HUNT** state:
  - cnt=0; din ignored.
  - en&fs → capture din as bit 0, cnt=1, miss=0, go LOCKED.
- **LOCKED** state, on each en cycle:
  - cnt=0, fs=1 → normal frame start; miss=0; capture bit 0; cnt=1.
  - cnt=0, fs=0 → flywheel: capture as bit 0 anyway; miss+1.
    - If miss reaches MAX_MISS: go HUNT, discard bit, cnt=0, miss=0.
  - cnt≠0, fs=0 → capture bit, cnt+1 (wrap after F-1).
  - cnt≠0, fs=1 → misplaced sync:
    - sync_err pulse;
    - discard partial frame (no frame_valid);
    - capture din as bit 0, cnt=1, miss=0;
    - stay LOCKED.
- Frame completion: when bit F-1 is captured in LOCKED, the full shift image is copied to ch_data and frame_valid pulses.
- en=0 cycles: no state change, no capture; counters hold.
- ch_data holds its last frame through HUNT, sync errors and en gaps; only rst or a completed frame changes it.

## Timing
- Reset values: ch_data=0, frame_valid=0, locked=0, sync_err=0, state HUNT, cnt=0, miss=0.
- rst dominates all inputs in the same cycle. A partial frame in flight at rst is lost.
- Latency: frame_valid and new ch_data are registered outputs, visible the cycle after the edge that samples bit F-1.
- frame_valid is exactly one cycle wide, even if en is held high continuously.
  - Back-to-back frames at en=1 produce frame_valid every F cycles.
- sync_err is registered and appears the cycle after the offending sample. It never coincides with frame_valid for the same frame.
- locked:
  - rises the cycle after the HUNT→LOCKED sample;
  - falls the cycle after the MAX_MISS-th missed sync is sampled.
- fs with en=0 is ignored.

## Structure
- Package tdm_pkg holds:
  - state enum (HUNT, LOCKED);
  - localparam-style function for frame length F;
  - function for counter width $clog2(F).
- One sub-module, tdm_shift_in:
  - F-bit serial-in shift register with load-zero on start-of-frame;
  - enable from the parent FSM.
- FSM, counters and output registers live in tdm_demux.

## Test plan
All scenarios use defaults: CHANNELS=4, WIDTH=8, F=32.
- **Reset:** assert rst 2 cycles → all outputs 0, locked=0; fs pulses during rst are ignored.
- **Basic frame:** fs with first bit, en=1, stream ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x00 → one cycle after bit 31: ch_data=0x00FF3CA5, frame_valid=1 for one cycle, locked=1 from cycle 1.
- **Gapped strobe:** same frame with en low every other cycle → identical ch_data=0x00FF3CA5, frame_valid once, no sync_err.
- **Early sync:** after 10 bits of a frame, fs=1 → sync_err pulse, no frame_valid for the aborted frame. Then a clean 32-bit frame 0x11223344 → ch_data=0x11223344.
- **Flywheel and loss:**
  - Lock, then omit fs on the next 2 frame starts → frames still delivered, locked=1.
  - Omit a 3rd consecutive fs → locked falls, no further frame_valid until a new fs.
  - ch_data retains the last value.
- **Reset mid-frame:** rst at bit 17 → outputs cleared, HUNT. The next fs-aligned frame 0xDEADBEEF is captured correctly.
